// File: rtl/sdram_pkg.sv
// sdram_pkg: definitions shared by the SDRAM bus interface and its upstream clients.
// Holds the default word-address width, the bus data width, the state encodings
// of the loader's load FSM and write engine, and a byte-to-word packing helper.
package sdram_pkg;

  localparam int SDRAM_ADDR_BITS = 22;  // {ba, col, row} word address
  localparam int SDRAM_DATA_BITS = 16;

  // Load FSM: accept bytes, wait for the FIFO to drain, report completion.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } load_state_e;

  // Write engine: one bus transaction at a time.
  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_REQ  = 2'd1,
    WR_GAP  = 2'd2
  } wr_state_e;

  // Little-endian packing: the earlier byte lands in the low half.
  function automatic logic [SDRAM_DATA_BITS-1:0] pack_word(input logic [7:0] lo_byte,
                                                           input logic [7:0] hi_byte);
    return {hi_byte, lo_byte};
  endfunction

endpackage

// File: rtl/sdram_loader_if.sv
// sdram_bus: one request channel into the SDRAM controller.
//   req        master -> slave  write request, held until completion
//   we         master -> slave  write enable (1 for every loader transaction)
//   address    master -> slave  word address {ba, col, row}
//   data_write master -> slave  16-bit write word
//   busy       slave  -> master raised with req, falls when the access completes
interface sdram_bus #(
  parameter int ADDR_BITS = sdram_pkg::SDRAM_ADDR_BITS
) ();

  logic                                 req;
  logic                                 we;
  logic [ADDR_BITS-1:0]                 address;
  logic [sdram_pkg::SDRAM_DATA_BITS-1:0] data_write;
  logic                                 busy;

  modport master (
    output req, we, address, data_write,
    input  busy
  );

  modport slave (
    input  req, we, address, data_write,
    output busy
  );

endinterface

// File: rtl/sdram_loader_fifo.sv
// sdram_loader_fifo: small synchronous FIFO for packed SDRAM words.
//   clk, rst_n  clock and asynchronous active-low reset
//   push/push_data  write side; ignored when full unless a pop frees the slot
//   pop/pop_data    read side; pop_data shows the head entry (first-word fall-through)
//   full/empty      status flags derived from pointers with one extra wrap bit
module sdram_loader_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_BITS = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem_r [DEPTH];
  logic [PTR_BITS:0] wr_ptr_r;
  logic [PTR_BITS:0] rd_ptr_r;
  logic              full_s;
  logic              empty_s;
  logic              wr_en_s;
  logic              rd_en_s;

  // Same index with differing wrap bits means every slot is occupied.
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[PTR_BITS] != rd_ptr_r[PTR_BITS]) &&
                   (wr_ptr_r[PTR_BITS-1:0] == rd_ptr_r[PTR_BITS-1:0]);

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign rd_en_s = pop && !empty_s;
  assign wr_en_s = push && (!full_s || rd_en_s);

  assign pop_data = mem_r[rd_ptr_r[PTR_BITS-1:0]];
  assign full     = full_s;
  assign empty    = empty_s;

  // Storage and pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(PTR_BITS+1){1'b0}};
      rd_ptr_r <= {(PTR_BITS+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r[PTR_BITS-1:0]] <= push_data;
        wr_ptr_r <= wr_ptr_r + {{PTR_BITS{1'b0}}, 1'b1};
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + {{PTR_BITS{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/sdram_loader.sv
// sdram_loader: packs a byte stream into 16-bit little-endian words and writes them
// to consecutive SDRAM word addresses through one sdram_bus master channel.
//   sdram_clk, rst_n          clock shared with the controller, async active-low reset
//   start, start_addr         1-cycle pulse latching the first word address (IDLE only)
//   s_data/s_valid/s_last     byte stream; s_last marks the final byte
//   s_ready                   byte accepted on s_valid && s_ready
//   active                    load in progress
//   done                      1-cycle pulse once the last word is written
//   words                     words written in the current/last load (wraps)
//   bus                       sdram_bus master (req, we, address, data_write; busy in)
module sdram_loader
  import sdram_pkg::*;
#(
  parameter int ADDR_BITS  = SDRAM_ADDR_BITS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 sdram_clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] start_addr,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic                 active,
  output logic                 done,
  output logic [ADDR_BITS-1:0] words,
  sdram_bus.master             bus
);

  localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  load_state_e                load_state_r;
  wr_state_e                  wr_state_r;
  logic [ADDR_BITS-1:0]       base_r;
  logic [ADDR_BITS-1:0]       words_r;
  logic                       active_r;
  logic                       done_r;
  logic                       last_seen_r;
  logic                       hi_phase_r;   // next accepted byte is the odd (high) byte
  logic [7:0]                 lo_byte_r;
  logic                       req_r;
  logic                       we_r;
  logic [ADDR_BITS-1:0]       addr_r;
  logic [SDRAM_DATA_BITS-1:0] data_r;

  logic                       s_ready_s;
  logic                       accept_s;
  logic                       start_accept_s;
  logic                       push_s;
  logic [SDRAM_DATA_BITS-1:0] push_data_s;
  logic                       pop_s;
  logic [SDRAM_DATA_BITS-1:0] fifo_dout_s;
  logic                       fifo_full_s;
  logic                       fifo_empty_s;
  logic                       wr_done_s;

  // s_ready is decoded from registered state only, so reset clears it at once.
  assign s_ready_s      = (load_state_r == FILL) && !fifo_full_s && !last_seen_r;
  assign accept_s       = s_valid && s_ready_s;
  assign start_accept_s = start && (load_state_r == IDLE);
  assign wr_done_s      = (wr_state_r == WR_REQ) && !bus.busy;
  assign pop_s          = ((wr_state_r == WR_IDLE) || (wr_state_r == WR_GAP)) && !fifo_empty_s;

  // Byte packer: push on every odd byte, or on an even byte that ends the load.
  always_comb begin
    push_s      = 1'b0;
    push_data_s = {SDRAM_DATA_BITS{1'b0}};
    if (accept_s) begin
      if (hi_phase_r) begin
        push_s      = 1'b1;
        push_data_s = pack_word(lo_byte_r, s_data);
      end else if (s_last) begin
        push_s      = 1'b1;
        push_data_s = pack_word(s_data, 8'h00);
      end else begin
        push_s      = 1'b0;
        push_data_s = {SDRAM_DATA_BITS{1'b0}};
      end
    end else begin
      push_s      = 1'b0;
      push_data_s = {SDRAM_DATA_BITS{1'b0}};
    end
  end

  sdram_loader_fifo #(
    .WIDTH (SDRAM_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (sdram_clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .pop_data  (fifo_dout_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Load FSM with byte packer state and the active/done outputs.
  always_ff @(posedge sdram_clk or negedge rst_n) begin
    if (!rst_n) begin
      load_state_r <= IDLE;
      base_r       <= {ADDR_BITS{1'b0}};
      active_r     <= 1'b0;
      done_r       <= 1'b0;
      last_seen_r  <= 1'b0;
      hi_phase_r   <= 1'b0;
      lo_byte_r    <= 8'h00;
    end else begin
      case (load_state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            base_r       <= start_addr;
            active_r     <= 1'b1;
            last_seen_r  <= 1'b0;
            hi_phase_r   <= 1'b0;
            load_state_r <= FILL;
          end
        end
        FILL: begin
          if (accept_s) begin
            if (hi_phase_r) begin
              hi_phase_r <= 1'b0;
            end else if (!s_last) begin
              lo_byte_r  <= s_data;
              hi_phase_r <= 1'b1;
            end
            if (s_last) begin
              last_seen_r  <= 1'b1;
              load_state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Outside WR_REQ the last popped word has already been acknowledged.
          if (fifo_empty_s && (wr_state_r != WR_REQ)) begin
            done_r       <= 1'b1;
            active_r     <= 1'b0;
            load_state_r <= DONE;
          end
        end
        DONE: begin
          done_r       <= 1'b0;
          load_state_r <= IDLE;
        end
        default: begin
          done_r       <= 1'b0;
          active_r     <= 1'b0;
          load_state_r <= IDLE;
        end
      endcase
    end
  end

  // Write engine: issue one request per FIFO word and wait for busy to fall.
  always_ff @(posedge sdram_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_r <= WR_IDLE;
      req_r      <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= {ADDR_BITS{1'b0}};
      data_r     <= {SDRAM_DATA_BITS{1'b0}};
    end else begin
      case (wr_state_r)
        WR_IDLE, WR_GAP: begin
          // WR_GAP is the single low cycle of req; it may issue the next word
          // directly so back-to-back writes keep a one-cycle gap.
          if (!fifo_empty_s) begin
            req_r      <= 1'b1;
            we_r       <= 1'b1;
            addr_r     <= base_r + words_r;
            data_r     <= fifo_dout_s;
            wr_state_r <= WR_REQ;
          end else begin
            wr_state_r <= WR_IDLE;
          end
        end
        WR_REQ: begin
          if (!bus.busy) begin
            req_r      <= 1'b0;
            we_r       <= 1'b0;
            wr_state_r <= WR_GAP;
          end
        end
        default: begin
          req_r      <= 1'b0;
          we_r       <= 1'b0;
          wr_state_r <= WR_IDLE;
        end
      endcase
    end
  end

  // Completed-word counter; cleared by an accepted start, wraps like the address.
  always_ff @(posedge sdram_clk or negedge rst_n) begin
    if (!rst_n) begin
      words_r <= {ADDR_BITS{1'b0}};
    end else if (start_accept_s) begin
      words_r <= {ADDR_BITS{1'b0}};
    end else if (wr_done_s) begin
      words_r <= words_r + ADDR_ONE;
    end
  end

  assign s_ready        = s_ready_s;
  assign active         = active_r;
  assign done           = done_r;
  assign words          = words_r;
  assign bus.req        = req_r;
  assign bus.we         = we_r;
  assign bus.address    = addr_r;
  assign bus.data_write = data_r;

endmodule

// File: tb/tb_sdram_loader.sv
// tb_sdram_loader: randomized self-checking bench for sdram_loader.
// A busy-timing BFM answers the bus; a monitor records every write; expected writes
// are computed from the byte list (pairs packed little-endian, address = start + i
// modulo 2**22) and compared with what the monitor saw.
module tb_sdram_loader;

  localparam int AB = 22;

  logic          sdram_clk = 1'b0;
  logic          rst_n     = 1'b0;
  logic          start     = 1'b0;
  logic [AB-1:0] start_addr = '0;
  logic [7:0]    s_data    = 8'h00;
  logic          s_valid   = 1'b0;
  logic          s_last    = 1'b0;
  logic          s_ready;
  logic          active;
  logic          done;
  logic [AB-1:0] words;

  sdram_bus #(.ADDR_BITS(AB)) bus ();

  sdram_loader #(.ADDR_BITS(AB), .FIFO_DEPTH(4)) dut (
    .sdram_clk  (sdram_clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .active     (active),
    .done       (done),
    .words      (words),
    .bus        (bus)
  );

  always #5 sdram_clk = ~sdram_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Busy BFM: busy rises with req and stays high for lat cycles.
  logic bfm_req_d = 1'b0;
  int   bfm_cnt   = 0;
  int   bfm_lat   = 0;   // 0 selects a random 6..9 cycle latency per write
  assign bus.busy = bus.req && (!bfm_req_d || (bfm_cnt != 0));

  always @(posedge sdram_clk) begin
    bfm_req_d <= bus.req;
    if (bus.req && !bfm_req_d) begin
      bfm_cnt <= ((bfm_lat != 0) ? bfm_lat : int'($urandom_range(9, 6))) - 1;
    end else if (bfm_cnt != 0) begin
      bfm_cnt <= bfm_cnt - 1;
    end
  end

  // Monitor: log writes, check stability while req is high and gap length.
  logic [AB+15:0] wr_q[$];
  logic           mon_req_d = 1'b0;
  logic [AB-1:0]  cap_addr  = '0;
  logic [15:0]    cap_data  = '0;
  int             low_cnt   = 0;
  int             done_cnt  = 0;
  bit             gap_chk_en = 1'b0;
  bit             gap_armed  = 1'b0;

  always @(negedge sdram_clk) begin
    if (bus.req && !mon_req_d) begin
      wr_q.push_back({bus.address, bus.data_write});
      cap_addr <= bus.address;
      cap_data <= bus.data_write;
      if (gap_chk_en && gap_armed) check_eq("req_gap", low_cnt, 1);
      gap_armed <= gap_chk_en;
      check_eq("we_on_req", {31'd0, bus.we}, 32'd1);
    end else if (bus.req && mon_req_d) begin
      check_eq("addr_stable", {10'd0, bus.address}, {10'd0, cap_addr});
      check_eq("data_stable", {16'd0, bus.data_write}, {16'd0, cap_data});
    end
    low_cnt   <= bus.req ? 0 : low_cnt + 1;
    mon_req_d <= bus.req;
    if (done) done_cnt <= done_cnt + 1;
  end

  logic [7:0] bq[$];

  // Drive one load from bq and check it against the reference expectation.
  task automatic run_load(input logic [AB-1:0] sa, input bit rand_valid,
                          input bit stray, input bit bp);
    int          n;
    int          nw;
    int          idx;
    int          cyc;
    int          w0;
    int          d0;
    bit          acc;
    bit          stray_done;
    bit          saw_stall;
    logic [AB-1:0] ea;
    logic [15:0]   ed;
    n  = bq.size();
    nw = (n + 1) / 2;
    w0 = wr_q.size();
    d0 = done_cnt;
    idx = 0; cyc = 0; stray_done = 1'b0; saw_stall = 1'b0;
    gap_chk_en = bp;
    @(negedge sdram_clk);
    start = 1'b1; start_addr = sa;
    @(negedge sdram_clk);
    start = 1'b0; start_addr = AB'($urandom);
    check_eq("active_after_start", {31'd0, active}, 32'd1);
    while (idx < n && cyc < 5000) begin
      s_valid = rand_valid ? ($urandom_range(3, 0) != 0) : 1'b1;
      s_data  = bq[idx];
      s_last  = (idx == n - 1);
      start   = stray && !stray_done && (idx == n / 2);
      if (start) stray_done = 1'b1;
      acc = s_valid && s_ready;
      if (s_valid && !s_ready) saw_stall = 1'b1;
      @(posedge sdram_clk);
      if (acc) idx++;
      cyc++;
      @(negedge sdram_clk);
      start = 1'b0;
    end
    check_eq("bytes_accepted", idx, n);
    s_valid = 1'b0; s_last = 1'b0;
    check_eq("s_ready_after_last", {31'd0, s_ready}, 32'd0);
    if (bp) check_eq("backpressure_seen", {31'd0, saw_stall}, 32'd1);
    cyc = 0;
    while (done_cnt == d0 && cyc < 3000) begin
      @(negedge sdram_clk);
      cyc++;
    end
    if (cyc >= 3000) check_eq("done_timeout", 32'd1, 32'd0);
    repeat (3) @(negedge sdram_clk);
    gap_chk_en = 1'b0;
    check_eq("done_pulses", done_cnt - d0, 1);
    check_eq("words", {10'd0, words}, nw);
    check_eq("active_end", {31'd0, active}, 32'd0);
    check_eq("write_count", wr_q.size() - w0, nw);
    for (int i = 0; i < nw && (w0 + i) < wr_q.size(); i++) begin
      ea = sa + AB'(i);
      ed = {(2 * i + 1 < n) ? bq[2 * i + 1] : 8'h00, bq[2 * i]};
      check_eq($sformatf("wr%0d_addr", i), {10'd0, wr_q[w0 + i][AB+15:16]}, {10'd0, ea});
      check_eq($sformatf("wr%0d_data", i), {16'd0, wr_q[w0 + i][15:0]}, {16'd0, ed});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    repeat (3) @(negedge sdram_clk);
    #1;
    check_eq("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check_eq("rst_active", {31'd0, active}, 32'd0);
    check_eq("rst_req", {31'd0, bus.req}, 32'd0);
    check_eq("rst_we", {31'd0, bus.we}, 32'd0);
    check_eq("rst_addr", {10'd0, bus.address}, 32'd0);
    check_eq("rst_data", {16'd0, bus.data_write}, 32'd0);
    @(negedge sdram_clk);
    rst_n = 1'b1;
    @(negedge sdram_clk);
    check_eq("idle_done", {31'd0, done}, 32'd0);
    check_eq("idle_words", {10'd0, words}, 32'd0);

    // Even length.
    bq = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(22'h000100, 1'b0, 1'b0, 1'b0);
    // Odd length: high byte of the last word padded.
    bq = '{8'hAA, 8'hBB, 8'hCC};
    run_load(22'h001234, 1'b1, 1'b0, 1'b0);
    // Address wrap.
    bq = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(22'h3FFFFF, 1'b0, 1'b0, 1'b0);
    // Back-pressure with a slow slave; stray start mid-load.
    bfm_lat = 20;
    bq.delete();
    for (int i = 0; i < 16; i++) bq.push_back(8'($urandom));
    run_load(22'h000040, 1'b0, 1'b1, 1'b1);
    bfm_lat = 0;
    // Randomized loads.
    for (int t = 0; t < 6; t++) begin
      bq.delete();
      for (int i = 0; i < int'($urandom_range(20, 1)); i++) bq.push_back(8'($urandom));
      run_load(AB'($urandom), 1'b1, (t % 2) == 1, 1'b0);
    end

    // Reset while a write is outstanding.
    bfm_lat = 9;
    @(negedge sdram_clk);
    start = 1'b1; start_addr = 22'h000200;
    @(negedge sdram_clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 8'(i + 8'h50); s_last = 1'b0;
      @(negedge sdram_clk);
    end
    s_valid = 1'b0;
    cyc = 0;
    while (!bus.req && cyc < 50) begin
      @(negedge sdram_clk);
      cyc++;
    end
    check_eq("req_before_reset", {31'd0, bus.req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_req", {31'd0, bus.req}, 32'd0);
    check_eq("async_active", {31'd0, active}, 32'd0);
    check_eq("async_s_ready", {31'd0, s_ready}, 32'd0);
    check_eq("async_words", {10'd0, words}, 32'd0);
    repeat (3) @(negedge sdram_clk);
    rst_n = 1'b1;
    repeat (12) @(negedge sdram_clk);
    bfm_lat = 0;
    bq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h77};
    run_load(22'h000300, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
